// File: rtl/branch_comp_seq.sv
// Multi-cycle RISC-V branch comparator: scans operands MSB-first one chunk per cycle,
// exits on the first differing chunk and registers eq/lt/taken/illegal behind valid/ready.
module branch_comp_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_rs1,
  input  logic [WIDTH-1:0] i_rs2,
  input  logic [2:0]       i_funct3,
  input  logic             i_flush,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic             o_br_eq,
  output logic             o_br_lt,
  output logic             o_br_taken,
  output logic             o_br_illegal
);

  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CHUNKS - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(32'd0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(32'd1);

  if (((WIDTH % CHUNK) != 0) || (WIDTH < CHUNK)) begin : g_bad_chunk
    $error("branch_comp_seq: WIDTH must be a non-zero multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Returns {illegal, taken}; the reserved encodings never take the branch.
  function automatic logic [1:0] decode_branch(input logic [2:0] f3, input logic eq, input logic lt);
    logic [1:0] res;
    case (f3)
      3'b000:          res = {1'b0, eq};
      3'b001:          res = {1'b0, ~eq};
      3'b100, 3'b110:  res = {1'b0, lt};
      3'b101, 3'b111:  res = {1'b0, ~lt};
      3'b010, 3'b011:  res = 2'b10;
      default:         res = 2'b00;
    endcase
    return res;
  endfunction

  function automatic logic [CHUNK-1:0] pick_chunk(input logic [WIDTH-1:0] v, input logic [IDX_W-1:0] idx);
    logic [CHUNK-1:0] c;
    c = {CHUNK{1'b0}};
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      c = (IDX_W'(i) == idx) ? v[i*CHUNK +: CHUNK] : c;
    end
    return c;
  endfunction

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [2:0]         r_f3;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic               r_eq, r_lt, r_taken, r_illegal;
  logic               w_eq_nxt, w_lt_nxt, w_taken_nxt, w_illegal_nxt;
  logic               w_load;
  logic               w_flip;
  logic [CHUNK-1:0]   w_a_chunk, w_b_chunk;
  logic               w_chunk_ne;
  logic               w_fin_eq, w_fin_lt;
  logic [1:0]         w_dec;

  // Signed mode biases the top chunk's sign bit so an unsigned chunk compare orders it correctly.
  assign w_flip     = (r_idx == IDX_LAST) && !r_f3[1];
  assign w_a_chunk  = pick_chunk(r_a, r_idx) ^ {w_flip, {(CHUNK-1){1'b0}}};
  assign w_b_chunk  = pick_chunk(r_b, r_idx) ^ {w_flip, {(CHUNK-1){1'b0}}};
  assign w_chunk_ne = (w_a_chunk != w_b_chunk);
  assign w_fin_eq   = !w_chunk_ne;
  assign w_fin_lt   = w_chunk_ne && (w_a_chunk < w_b_chunk);
  assign w_dec      = decode_branch(r_f3, w_fin_eq, w_fin_lt);

  assign o_in_ready   = (r_state == S_IDLE) && !i_reset;
  assign o_out_valid  = (r_state == S_DONE);
  assign o_br_eq      = r_eq;
  assign o_br_lt      = r_lt;
  assign o_br_taken   = r_taken;
  assign o_br_illegal = r_illegal;

  // Next-state and result update; flush wins over accept and over out_ready.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_eq_nxt      = r_eq;
    w_lt_nxt      = r_lt;
    w_taken_nxt   = r_taken;
    w_illegal_nxt = r_illegal;
    w_load        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_flush) begin
          w_state_nxt = S_IDLE;
        end else if (i_in_valid && o_in_ready) begin
          w_state_nxt = S_BUSY;
          w_idx_nxt   = IDX_LAST;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if (i_flush) begin
          w_state_nxt = S_IDLE;
        end else if (w_chunk_ne || (r_idx == IDX_ZERO)) begin
          w_state_nxt   = S_DONE;
          w_eq_nxt      = w_fin_eq;
          w_lt_nxt      = w_fin_lt;
          w_taken_nxt   = w_dec[0];
          w_illegal_nxt = w_dec[1];
        end else begin
          w_idx_nxt = r_idx - IDX_ONE;
        end
      end
      S_DONE: begin
        if (i_flush || i_out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, operand and result registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_idx     <= IDX_LAST;
      r_a       <= {WIDTH{1'b0}};
      r_b       <= {WIDTH{1'b0}};
      r_f3      <= 3'b000;
      r_eq      <= 1'b0;
      r_lt      <= 1'b0;
      r_taken   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_eq      <= w_eq_nxt;
      r_lt      <= w_lt_nxt;
      r_taken   <= w_taken_nxt;
      r_illegal <= w_illegal_nxt;
      if (w_load) begin
        r_a  <= i_rs1;
        r_b  <= i_rs2;
        r_f3 <= i_funct3;
      end
    end
  end

endmodule

// File: tb/tb_branch_comp_seq.sv
// Randomised and directed bench for branch_comp_seq (WIDTH=32, CHUNK=8) against a
// transaction-level model: whole-word compares plus a latency derived from the top differing byte.
module tb_branch_comp_seq;

  localparam int NC = 4;

  logic        clk, reset, in_valid, flush, out_ready;
  logic [31:0] rs1, rs2;
  logic [2:0]  f3;
  logic        in_ready, out_valid, br_eq, br_lt, br_taken, br_illegal;

  int n_chk = 0;
  int n_err = 0;

  bit m_busy, m_valid;
  int m_cnt;
  bit e_eq, e_lt, e_taken, e_ill;
  bit p_eq, p_lt, p_taken, p_ill;

  branch_comp_seq #(.WIDTH(32), .CHUNK(8)) dut (
    .i_clk(clk), .i_reset(reset), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_rs1(rs1), .i_rs2(rs2), .i_funct3(f3), .i_flush(flush),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_br_eq(br_eq), .o_br_lt(br_lt), .o_br_taken(br_taken), .o_br_illegal(br_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_compute(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                               output int lat, output bit eq, output bit lt,
                               output bit taken, output bit ill);
    logic [31:0] d;
    d   = a ^ b;
    lat = NC;
    for (int c = 0; c < NC; c++) begin
      if (((d >> (c * 8)) & 32'h0000_00FF) != 32'd0) lat = NC - c;
    end
    eq  = (a == b);
    lt  = f[1] ? (a < b) : ($signed(a) < $signed(b));
    ill = (f == 3'b010) || (f == 3'b011);
    case (f)
      3'b000:         taken = eq;
      3'b001:         taken = !eq;
      3'b100, 3'b110: taken = lt;
      3'b101, 3'b111: taken = !lt;
      default:        taken = 1'b0;
    endcase
  endtask

  // One clock: advance the model on the rising edge, compare every output on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_busy = 0; m_valid = 0; m_cnt = 0;
      e_eq = 0; e_lt = 0; e_taken = 0; e_ill = 0;
    end else if (flush) begin
      m_busy = 0; m_valid = 0;
    end else if (m_valid) begin
      if (out_ready) m_valid = 0;
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_busy = 0; m_valid = 1;
        e_eq = p_eq; e_lt = p_lt; e_taken = p_taken; e_ill = p_ill;
      end
    end else if (in_valid) begin
      m_busy = 1;
      model_compute(rs1, rs2, f3, m_cnt, p_eq, p_lt, p_taken, p_ill);
    end
    @(negedge clk);
    chk("in_ready",   in_ready,   (!reset && !m_busy && !m_valid));
    chk("out_valid",  out_valid,  m_valid);
    chk("br_eq",      br_eq,      e_eq);
    chk("br_lt",      br_lt,      e_lt);
    chk("br_taken",   br_taken,   e_taken);
    chk("br_illegal", br_illegal, e_ill);
  endtask

  task automatic txn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                     input int hold, input int x_lat, input bit x_eq, input bit x_lt,
                     input bit x_taken, input bit x_ill, input string tag);
    int lat;
    rs1 = a; rs2 = b; f3 = f; in_valid = 1'b1; out_ready = 1'b0;
    chk({tag, "_ready"}, in_ready, 32'd1);
    tick();
    in_valid = 1'b0; rs1 = $urandom; rs2 = $urandom; f3 = 3'($urandom_range(0, 7));
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat,        x_lat);
    chk({tag, "_eq"},      br_eq,      x_eq);
    chk({tag, "_lt"},      br_lt,      x_lt);
    chk({tag, "_taken"},   br_taken,   x_taken);
    chk({tag, "_illegal"}, br_illegal, x_ill);
    in_valid = 1'b1;
    for (int i = 0; i < hold; i++) tick();
    chk({tag, "_held"}, {out_valid, in_ready}, 32'd2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_released"}, {out_valid, in_ready}, 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    int lat, k;
    bit eq, lt, tk, il;
    logic [31:0] mask;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rs1 = 32'd0; rs2 = 32'd0; f3 = 3'd0;
    tick();
    tick();
    chk("reset_outputs", {in_ready, out_valid, br_eq, br_lt, br_taken, br_illegal}, 32'd0);
    reset = 1'b0;
    tick();

    model_compute(32'h8000_0000, 32'h7FFF_FFFF, 3'b100, lat, eq, lt, tk, il);
    chk("model_signed_min", {lat[3:0], eq, lt, tk, il}, {4'd1, 4'b0110});
    model_compute(32'h0000_0001, 32'h0000_0010, 3'b111, lat, eq, lt, tk, il);
    chk("model_low_chunk", {lat[3:0], eq, lt, tk, il}, {4'd4, 4'b0100});
    model_compute(32'h7FFF_FFFF, 32'hFFFF_FFFF, 3'b101, lat, eq, lt, tk, il);
    chk("model_bge", {lat[3:0], eq, lt, tk, il}, {4'd1, 4'b0010});

    txn(32'h5A5A_5A5A, 32'h5A5A_5A5A, 3'b000, 0, 4, 1, 0, 1, 0, "beq_equal");
    txn(32'h8000_0000, 32'h7FFF_FFFF, 3'b100, 1, 1, 0, 1, 1, 0, "blt_min");
    txn(32'h8000_0000, 32'h7FFF_FFFF, 3'b110, 0, 1, 0, 0, 0, 0, "bltu_min");
    txn(32'h0000_0001, 32'h0000_0010, 3'b111, 2, 4, 0, 1, 0, 0, "bgeu_low");
    txn(32'h7FFF_FFFF, 32'hFFFF_FFFF, 3'b101, 0, 1, 0, 0, 1, 0, "bge_sign");
    txn(32'h0000_0001, 32'h0000_0002, 3'b011, 0, 4, 0, 1, 0, 1, "illegal");
    txn(32'h1234_5678, 32'h1234_5678, 3'b001, 5, 4, 1, 0, 0, 0, "bne_stall");

    rs1 = 32'hCAFE_F00D; rs2 = 32'hCAFE_F00D; f3 = 3'b000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_idle", {out_valid, in_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("flush_no_valid", out_valid, 32'd0);
    end

    rs1 = 32'h5A5A_5A5A; rs2 = 32'h5A5A_5A5A; f3 = 3'b000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("done_before_reset", {out_valid, br_eq, br_taken}, 32'd7);
    reset = 1'b1;
    tick();
    chk("reset_in_done", {in_ready, out_valid, br_eq, br_lt, br_taken, br_illegal}, 32'd0);
    reset = 1'b0;
    tick();

    for (int n = 0; n < 4000; n++) begin
      reset     = ($urandom_range(0, 149) == 0);
      flush     = ($urandom_range(0, 24) == 0);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      f3        = 3'($urandom_range(0, 7));
      rs1       = $urandom;
      k         = $urandom_range(0, 5);
      if (k == 0)      mask = 32'd0;
      else if (k >= 4) mask = 32'hFFFF_FFFF;
      else             mask = (32'd1 << (8 * k)) - 32'd1;
      rs2 = rs1 ^ ($urandom & mask);
      if ($urandom_range(0, 7) == 0) rs2 = rs1 ^ 32'h8000_0000;
      tick();
    end

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
